// File: rtl/float_operand_source.sv
// Initiator side of the FPU stb/ack operand handshake: emits COUNT operand pairs.
// Optional macro FLOAT_OPERAND_SOURCE_LFSR_EN: operand B comes from a Galois LFSR.
module float_operand_source #(
    parameter logic [31:0] A_INIT = 32'h40000000,
    parameter logic [31:0] B_INIT = 32'h40000000,
    parameter logic [31:0] A_STEP = 32'd1,
    parameter logic [31:0] B_STEP = 32'd0,
    parameter logic [15:0] COUNT  = 16'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] output_a,
    output logic        output_a_stb,
    input  logic        output_a_ack,
    output logic [31:0] output_b,
    output logic        output_b_stb,
    input  logic        output_b_ack,
    output logic        busy,
    output logic        done,
    output logic [15:0] pair_count
);

    typedef enum logic [1:0] {IDLE, SEND, NEXT, DONE} state_t;

    state_t      state, state_n;
    logic [31:0] a_n, b_n;
    logic        stb_a_n, stb_b_n;
    logic        sent_a, sent_b, sent_a_n, sent_b_n;
    logic [15:0] pc_n;
    logic [31:0] b_seed, b_step_val;

`ifdef FLOAT_OPERAND_SOURCE_LFSR_EN
    // LFSR must never be seeded with zero or it locks up
    assign b_seed = (B_INIT == 32'd0) ? 32'h00000001 : B_INIT;
    // Galois LFSR step, right-shifting, taps 32'h80200003
    always_comb begin
        b_step_val = output_b >> 1;
        if (output_b[0]) b_step_val = b_step_val ^ 32'h80200003;
    end
`else
    assign b_seed     = B_INIT;
    assign b_step_val = output_b + B_STEP;
`endif

    assign busy = (state == SEND) || (state == NEXT);
    assign done = (state == DONE);

    // Next-state and next-data logic for the handshake sequencer
    always_comb begin
        state_n  = state;
        a_n      = output_a;
        b_n      = output_b;
        stb_a_n  = output_a_stb;
        stb_b_n  = output_b_stb;
        sent_a_n = sent_a;
        sent_b_n = sent_b;
        pc_n     = pair_count;
        unique case (state)
            IDLE: begin
                if (start) begin
                    pc_n = 16'd0;
                    if (COUNT != 16'd0) begin
                        a_n      = A_INIT;
                        b_n      = b_seed;
                        stb_a_n  = 1'b1;
                        stb_b_n  = 1'b1;
                        sent_a_n = 1'b0;
                        sent_b_n = 1'b0;
                        state_n  = SEND;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            SEND: begin
                sent_a_n = sent_a | (output_a_stb & output_a_ack);
                sent_b_n = sent_b | (output_b_stb & output_b_ack);
                stb_a_n  = output_a_stb & ~output_a_ack;
                stb_b_n  = output_b_stb & ~output_b_ack;
                if (sent_a_n && sent_b_n) begin
                    pc_n    = pair_count + 16'd1;
                    state_n = (pc_n == COUNT) ? DONE : NEXT;
                end
            end
            NEXT: begin
                a_n      = output_a + A_STEP;
                b_n      = b_step_val;
                sent_a_n = 1'b0;
                sent_b_n = 1'b0;
                stb_a_n  = 1'b1;
                stb_b_n  = 1'b1;
                state_n  = SEND;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            output_a     <= 32'd0;
            output_b     <= 32'd0;
            output_a_stb <= 1'b0;
            output_b_stb <= 1'b0;
            sent_a       <= 1'b0;
            sent_b       <= 1'b0;
            pair_count   <= 16'd0;
        end else begin
            state        <= state_n;
            output_a     <= a_n;
            output_b     <= b_n;
            output_a_stb <= stb_a_n;
            output_b_stb <= stb_b_n;
            sent_a       <= sent_a_n;
            sent_b       <= sent_b_n;
            pair_count   <= pc_n;
        end
    end

endmodule

// File: tb/tb_float_operand_source.sv
// Directed bench for float_operand_source: default run, stalls, reset abort,
// wrap, zero count and operand B sequencing (LFSR or stepped).
module tb_float_operand_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, a_ack, b_ack;
    logic [31:0] a, b;
    logic a_stb, b_stb, busy, done;
    logic [15:0] pc;

    logic s1, s2, s3;
    logic [31:0] a1, b1, a2, b2, a3, b3;
    logic as1, bs1, as2, bs2, as3, bs3;
    logic bz1, bz2, bz3, d1, d2, d3;
    logic [15:0] pc1, pc2, pc3;

    int n_cmp = 0;
    int n_err = 0;

    float_operand_source u_dut (
        .clk(clk), .rst(rst), .start(start),
        .output_a(a), .output_a_stb(a_stb), .output_a_ack(a_ack),
        .output_b(b), .output_b_stb(b_stb), .output_b_ack(b_ack),
        .busy(busy), .done(done), .pair_count(pc)
    );

    float_operand_source #(.A_INIT(32'hFFFFFFFF), .COUNT(16'd2)) u_wrap (
        .clk(clk), .rst(rst), .start(s1),
        .output_a(a1), .output_a_stb(as1), .output_a_ack(1'b1),
        .output_b(b1), .output_b_stb(bs1), .output_b_ack(1'b1),
        .busy(bz1), .done(d1), .pair_count(pc1)
    );

    float_operand_source #(.COUNT(16'd0)) u_zero (
        .clk(clk), .rst(rst), .start(s2),
        .output_a(a2), .output_a_stb(as2), .output_a_ack(1'b1),
        .output_b(b2), .output_b_stb(bs2), .output_b_ack(1'b1),
        .busy(bz2), .done(d2), .pair_count(pc2)
    );

    float_operand_source #(.B_INIT(32'd0), .B_STEP(32'd5), .COUNT(16'd2)) u_bseq (
        .clk(clk), .rst(rst), .start(s3),
        .output_a(a3), .output_a_stb(as3), .output_a_ack(1'b1),
        .output_b(b3), .output_b_stb(bs3), .output_b_ack(1'b1),
        .busy(bz3), .done(d3), .pair_count(pc3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        int waited;
        rst = 1'b1; start = 1'b0; a_ack = 1'b1; b_ack = 1'b1;
        s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_a", a, 32'd0);
        check("rst_stb", {30'd0, a_stb, b_stb}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_pc", {16'd0, pc}, 32'd0);
        rst = 1'b0;

        // Default run with both acks held high
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("p%0d_stb", i), {30'd0, a_stb, b_stb}, 32'd3);
            check($sformatf("p%0d_a", i), a, 32'h40000000 + i);
            check($sformatf("p%0d_b", i), b, 32'h40000000);
            check($sformatf("p%0d_pc", i), {16'd0, pc}, i);
            if (i == 5) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (i < 15) begin
                check($sformatf("n%0d_low", i),
                      {29'd0, a_stb, b_stb, busy}, 32'd1);
                @(negedge clk);
            end else begin
                check("done_pulse", {30'd0, done, busy}, 32'd2);
                check("done_pc", {16'd0, pc}, 32'd16);
                check("done_stb", {30'd0, a_stb, b_stb}, 32'd0);
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("post_done", {29'd0, done, busy, a_stb}, 32'd0);
        check("held_a", a, 32'h4000000F);
        check("held_pc", {16'd0, pc}, 32'd16);
        @(negedge clk);
        check("start_in_done_ignored", {29'd0, done, busy, a_stb}, 32'd0);

        // A stalls 5 cycles, B accepts at once
        a_ack = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("stall_first", {30'd0, a_stb, b_stb}, 32'd3);
        check("stall_pc0", {16'd0, pc}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_stb", k), {30'd0, a_stb, b_stb}, 32'd2);
            check($sformatf("stall%0d_a", k), a, 32'h40000000);
            check($sformatf("stall%0d_pc", k), {16'd0, pc}, 32'd0);
        end
        a_ack = 1'b1;
        @(negedge clk);
        check("stall_done_pc", {16'd0, pc}, 32'd1);
        check("stall_done_stb", {30'd0, a_stb, b_stb}, 32'd0);

        // Run until 3 pairs done, then leave A pending and reset
        waited = 0;
        while (pc != 16'd3 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("reach_pc3", {16'd0, pc}, 32'd3);
        a_ack = 1'b0;
        @(negedge clk);
        check("pend_stb", {30'd0, a_stb, b_stb}, 32'd3);
        check("pend_a", a, 32'h40000003);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out", {a, b} == 64'd0 ? 32'd0 : 32'd1, 32'd0);
        check("abort_ctl", {28'd0, a_stb, b_stb, busy, done}, 32'd0);
        check("abort_pc", {16'd0, pc}, 32'd0);
        a_ack = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_a", a, 32'h40000000);
        check("restart_pc", {16'd0, pc}, 32'd0);
        @(negedge clk);
        check("restart_pc1", {16'd0, pc}, 32'd1);

        // Wrap, zero count, operand B sequencing
        s1 = 1'b1; s2 = 1'b1; s3 = 1'b1;
        @(negedge clk);
        s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
        check("wrap_a0", a1, 32'hFFFFFFFF);
        check("zero_done", {28'd0, d2, bz2, as2, bs2}, 32'd8);
        check("zero_pc", {16'd0, pc2}, 32'd0);
        check("bseq_b0", b3,
`ifdef FLOAT_OPERAND_SOURCE_LFSR_EN
              32'h00000001);
`else
              32'h00000000);
`endif
        @(negedge clk);
        check("zero_after", {28'd0, d2, bz2, as2, bs2}, 32'd0);
        @(negedge clk);
        check("wrap_a1", a1, 32'h00000000);
        check("bseq_b1", b3,
`ifdef FLOAT_OPERAND_SOURCE_LFSR_EN
              32'h80200003);
`else
              32'h00000005);
`endif
        @(negedge clk);
        check("wrap_done", {30'd0, d1, as1}, 32'd2);
        check("wrap_pc", {16'd0, pc1}, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/float_operand_source.md
Name: float_operand_source

Overview:
- Initiator end of the stb/ack operand handshake used by the FPU cores (multiplier, adder, divider input_a/input_b channels).
- Emits COUNT pairs of 32-bit operands on two independent channels, starting from configurable IEEE-754 seeds and stepping the raw bit patterns each pair.
- Replaces hand-written stimulus loops in benches and doubles as an on-chip self-test source ahead of an FPU core.

Parameters:
- A_INIT, 32'h40000000, first operand A (2.0)
- B_INIT, 32'h40000000, first operand B (2.0)
- A_STEP, 32'd1, raw increment added to A after each completed pair
- B_STEP, 32'd0, raw increment added to B after each completed pair
- COUNT, 16'd16, number of pairs per run (0 allowed)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a run; sampled only in IDLE
- output_a  out  32  operand A data
- output_a_stb  out  1  A valid
- output_a_ack  in  1  A accepted by consumer
- output_b  out  32  operand B data
- output_b_stb  out  1  B valid
- output_b_ack  in  1  B accepted by consumer
- busy  out  1  high in SEND/NEXT
- done  out  1  one-cycle pulse at end of run
- pair_count  out  16  pairs completed in current/last run

Behaviour:
- Reset: all outputs 0 on the first edge with rst=1. State goes to IDLE and both sent flags clear. A reset mid-run aborts the run and drops both stb immediately; no partial pair is counted.
- Transfer rule: a channel transfers on a rising edge where stb=1 and ack=1. An ack while stb=0 is ignored. Data is held stable while stb=1.
- States: IDLE, SEND, NEXT, DONE.
- IDLE:
  - stb=0, busy=0.
  - start=1 with COUNT!=0: load output_a=A_INIT, output_b=B_INIT, pair_count=0, assert both stb, go to SEND. Both stb are visible in the cycle after the start edge.
  - start=1 with COUNT=0: go to DONE with no stb activity.
- SEND:
  - Each channel is independent. On its transfer edge the channel drops its stb and sets its sent flag.
  - The pair completes on the edge where both flags are set, or would be set. This includes both acks arriving in the same cycle, or the second ack arriving any later cycle.
  - On completion: pair_count+1. If the new pair_count equals COUNT, go to DONE; otherwise go to NEXT.
- NEXT (exactly 1 cycle):
  - Both stb stay low.
  - output_a += A_STEP and output_b += B_STEP, modulo 2^32 (wraps silently, no saturation).
  - Flags clear, both stb reassert, return to SEND.
  - Minimum spacing between pairs is therefore one low-stb cycle.
- DONE: done=1 for exactly one cycle, busy=0, go to IDLE. Output data and pair_count are held until the next start.
- start while busy is ignored. start in the DONE cycle is ignored; a new run needs start in IDLE.
- ack held high continuously is legal: each pair transfers one cycle after stb rises, giving a steady-state throughput of 1 pair per 2 cycles.

Optional Feature:
- Macro: FLOAT_OPERAND_SOURCE_LFSR_EN.
- Defined: output_b comes from a 32-bit Galois LFSR (taps mask 32'h80200003), seeded with B_INIT, or with 32'h00000001 if B_INIT=0. It advances one step per NEXT; B_STEP is ignored.
- Not defined: output_b += B_STEP as above, and no LFSR logic is present.

Test Plan:
- Defaults, output_a_ack=output_b_ack=1 constant, start pulse: 16 pairs. A runs 40000000,40000001,…,4000000F and B stays 40000000. done pulses once, pair_count=16, and stb toggles high/low each cycle.
- output_a_ack held 0 for 5 cycles, output_b_ack=1: B transfers and drops stb; output_a_stb and output_a stay high and stable; the pair completes only on A's ack edge, and pair_count increments once.
- A_INIT=32'hFFFFFFFF, A_STEP=1, COUNT=2: second A = 32'h00000000 (wrap).
- COUNT=0, start: done pulses the cycle after start; stb never asserts; pair_count=0.
- rst asserted after pair 3 of 16 with A stb pending: next cycle all outputs 0 and state IDLE. A new start reloads A_INIT/B_INIT and pair_count counts from 0.
- LFSR build, B_INIT=0: first B=32'h00000001, second B=32'h80200003. An ack pulse while stb=0, or a start while busy, has no effect.
